// File: rtl/shift_subtract_divider.sv
// ============================================================================
// Module   : shift_subtract_divider
// Purpose  : Sequential unsigned restoring divider, one shift/subtract
//            iteration every two clocks, with start/ready handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_subtract_divider #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         ready,
  output logic         busy,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] SHIFTING    = 2'd1;
  localparam logic [1:0] SUBTRACTING = 2'd2;
  localparam logic [1:0] STOPPED     = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [N:0]    a_reg;
  logic [N-1:0]  q_reg;
  logic [N-1:0]  m_reg;
  logic [CW-1:0] count;

  logic          accept;
  logic          fits;
  logic [N:0]    a_next_sub;
  logic [N-1:0]  q_next_sub;

  assign accept     = start && ((state == IDLE) || (state == STOPPED));
  assign fits       = (a_reg >= {1'b0, m_reg});
  // Restoring step: keep the difference only when the divisor fits.
  assign a_next_sub = fits ? (a_reg - {1'b0, m_reg}) : a_reg;
  assign q_next_sub = {q_reg[N-1:1], fits};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, STOPPED: begin
        if (accept) begin
          state_next = (divisor == '0) ? STOPPED : SHIFTING;
        end
      end
      SHIFTING:    state_next = SUBTRACTING;
      SUBTRACTING: state_next = (count == '0) ? STOPPED : SHIFTING;
      default:     state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == STOPPED);
    busy  = (state == SHIFTING) || (state == SUBTRACTING);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      a_reg       <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, STOPPED: begin
          if (accept) begin
            if (divisor != '0) begin
              a_reg       <= '0;
              q_reg       <= dividend;
              m_reg       <= divisor;
              count       <= CW'(N);
              div_by_zero <= 1'b0;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        SHIFTING: begin
          {a_reg, q_reg} <= {a_reg[N-1:0], q_reg, 1'b0};
          count          <= count - 1'b1;
        end
        SUBTRACTING: begin
          a_reg <= a_next_sub;
          q_reg <= q_next_sub;
          if (count == '0) begin
            quotient  <= q_next_sub;
            remainder <= a_next_sub[N-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_subtract_divider.sv
// ============================================================================
// Module   : tb_shift_subtract_divider
// Purpose  : Self-checking bench for N=4 and N=8 dividers against a / and %
//            reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_shift_subtract_divider;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       s4, s8;
  logic [3:0] a4, b4, q4, r4;
  logic [7:0] a8, b8, q8, r8;
  logic       rdy4, bsy4, dz4, rdy8, bsy8, dz8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  shift_subtract_divider #(.N(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .start(s4), .dividend(a4), .divisor(b4),
    .quotient(q4), .remainder(r4), .ready(rdy4), .busy(bsy4), .div_by_zero(dz4)
  );

  shift_subtract_divider #(.N(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .start(s8), .dividend(a8), .divisor(b8),
    .quotient(q8), .remainder(r8), .ready(rdy8), .busy(bsy8), .div_by_zero(dz8)
  );

  // Reference: plain integer division; divisor 0 yields all-ones / dividend.
  function automatic int ref_q(input int a, input int b, input int n);
    return (b == 0) ? ((1 << n) - 1) : (a / b);
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? a : (a % b);
  endfunction

  // Number of negedge samples from the accept edge until ready is seen.
  function automatic int ref_lat(input int b, input int n);
    return (b == 0) ? 1 : (2 * n + 1);
  endfunction

  task automatic go(input bit wide, input int a, input int b);
    if (wide) begin s8 = 1'b1; a8 = 8'(a); b8 = 8'(b); end
    else      begin s4 = 1'b1; a4 = 4'(a); b4 = 4'(b); end
  endtask

  task automatic wait_done(input bit wide, output int cyc, output int bcnt,
                           output bit ovl);
    bit rdy, bsy;
    cyc = 0; bcnt = 0; ovl = 1'b0;
    @(posedge clock); #1;
    if (wide) s8 = 1'b0; else s4 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      cyc++;
      rdy = wide ? rdy8 : rdy4;
      bsy = wide ? bsy8 : bsy4;
      if (rdy && bsy) ovl = 1'b1;
      if (bsy) bcnt++;
      if (rdy) break;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s4 = 0; s8 = 0; a4 = 0; b4 = 0; a8 = 0; b8 = 0;
    repeat (2) @(negedge clock);
    n_tests++;
    if ({q4, r4, rdy4, bsy4, dz4} !== 11'd0) begin
      n_fail++; $display("FAIL reset4: got %h expected 0", {q4, r4, rdy4, bsy4, dz4});
    end
    n_tests++;
    if ({q8, r8, rdy8, bsy8, dz8} !== 19'd0) begin
      n_fail++; $display("FAIL reset8: got %h expected 0", {q8, r8, rdy8, bsy8, dz8});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    n_tests++;
    if (rdy4 !== 1'b0 || bsy4 !== 1'b0) begin
      n_fail++; $display("FAIL idle4: got ready=%b busy=%b expected 0 0", rdy4, bsy4);
    end
  endtask

  task automatic test_basic();
    int cyc, bcnt; bit ovl;
    go(0, 13, 3);
    wait_done(0, cyc, bcnt, ovl);
    n_tests++;
    if (cyc != ref_lat(3, 4) || bcnt != 8 || ovl) begin
      n_fail++; $display("FAIL basic_timing: got lat=%0d busy=%0d ovl=%b expected %0d 8 0",
                         cyc, bcnt, ovl, ref_lat(3, 4));
    end
    n_tests++;
    if (q4 !== 4'(ref_q(13, 3, 4)) || r4 !== 4'(ref_r(13, 3)) || dz4 !== 1'b0) begin
      n_fail++; $display("FAIL basic_result: got %0d r %0d dz=%b expected 4 r 1 dz=0", q4, r4, dz4);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcnt; bit ovl;
    go(0, 3, 5);
    wait_done(0, cyc, bcnt, ovl);
    n_tests++;
    if (q4 !== 4'd0 || r4 !== 4'd3) begin
      n_fail++; $display("FAIL b2b_first: got %0d r %0d expected 0 r 3", q4, r4);
    end
    go(0, 15, 1);  // issued in the same cycle ready is seen
    wait_done(0, cyc, bcnt, ovl);
    n_tests++;
    if (cyc != ref_lat(1, 4) || q4 !== 4'd15 || r4 !== 4'd0 || ovl) begin
      n_fail++; $display("FAIL b2b_second: got lat=%0d %0d r %0d expected %0d 15 r 0",
                         cyc, q4, r4, ref_lat(1, 4));
    end
  endtask

  task automatic test_div_zero();
    int cyc, bcnt; bit ovl;
    go(0, 7, 0);
    wait_done(0, cyc, bcnt, ovl);
    n_tests++;
    if (cyc != 1 || bcnt != 0) begin
      n_fail++; $display("FAIL dz_timing: got lat=%0d busy=%0d expected 1 0", cyc, bcnt);
    end
    n_tests++;
    if (q4 !== 4'hF || r4 !== 4'd7 || dz4 !== 1'b1) begin
      n_fail++; $display("FAIL dz_result: got %h r %0d dz=%b expected F r 7 dz=1", q4, r4, dz4);
    end
  endtask

  task automatic test_ignore_start();
    int cyc = 0; bit held = 1'b1;
    go(0, 13, 3);
    @(posedge clock); #1; s4 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      cyc++;
      if (rdy4) break;
      if (q4 !== 4'hF || r4 !== 4'd7) held = 1'b0;
      if (cyc == 3) begin
        go(0, 9, 2);
        @(posedge clock); #1; s4 = 1'b0;
        @(negedge clock);
        cyc++;
        if (rdy4) break;
      end
    end
    n_tests++;
    if (!held) begin
      n_fail++; $display("FAIL hold_prev: got changed outputs expected F r 7 held");
    end
    n_tests++;
    if (cyc != 9 || q4 !== 4'd4 || r4 !== 4'd1 || dz4 !== 1'b0) begin
      n_fail++; $display("FAIL ignore_start: got lat=%0d %0d r %0d expected 9 4 r 1", cyc, q4, r4);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, bcnt; bit ovl;
    go(0, 13, 3);
    @(posedge clock); #1; s4 = 1'b0;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock); #1;
    n_tests++;
    if ({q4, r4, rdy4, bsy4, dz4} !== 11'd0) begin
      n_fail++; $display("FAIL reset_mid: got %h expected 0", {q4, r4, rdy4, bsy4, dz4});
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    go(0, 10, 4);
    wait_done(0, cyc, bcnt, ovl);
    n_tests++;
    if (cyc != ref_lat(4, 4) || q4 !== 4'd2 || r4 !== 4'd2) begin
      n_fail++; $display("FAIL after_reset: got lat=%0d %0d r %0d expected %0d 2 r 2",
                         cyc, q4, r4, ref_lat(4, 4));
    end
  endtask

  task automatic test_n8();
    int cyc, bcnt; bit ovl;
    go(1, 200, 7);
    wait_done(1, cyc, bcnt, ovl);
    n_tests++;
    if (cyc != 17 || bcnt != 16 || q8 !== 8'd28 || r8 !== 8'd4 || dz8 !== 1'b0) begin
      n_fail++; $display("FAIL n8_fixed: got lat=%0d busy=%0d %0d r %0d expected 17 16 28 r 4",
                         cyc, bcnt, q8, r8);
    end
  endtask

  task automatic test_random();
    int cyc, bcnt, a, b, n, gq, gr, gd; bit ovl, wide;
    for (int i = 0; i < 60; i++) begin
      wide = (i >= 30);
      n = wide ? 8 : 4;
      a = $urandom_range((1 << n) - 1, 0);
      b = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range((1 << n) - 1, 0);
      go(wide, a, b);
      wait_done(wide, cyc, bcnt, ovl);
      gq = wide ? int'(q8) : int'(q4);
      gr = wide ? int'(r8) : int'(r4);
      gd = wide ? int'(dz8) : int'(dz4);
      n_tests++;
      if (gq != ref_q(a, b, n) || gr != ref_r(a, b) || gd != int'(b == 0) ||
          cyc != ref_lat(b, n) || ovl) begin
        n_fail++;
        $display("FAIL rand_n%0d %0d/%0d: got %0d r %0d dz=%0d lat=%0d expected %0d r %0d dz=%0d lat=%0d",
                 n, a, b, gq, gr, gd, cyc, ref_q(a, b, n), ref_r(a, b), int'(b == 0), ref_lat(b, n));
      end
      if (b != 0) begin
        n_tests++;
        if (gq * b + gr != a || gr >= b) begin
          n_fail++; $display("FAIL invariant_n%0d %0d/%0d: got q=%0d r=%0d", n, a, b, gq, gr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_n8();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_subtract_divider.md
Name: shift_subtract_divider

Overview:
Sequential unsigned restoring divider, the inverse companion of the add-shift multiplier. It takes an N-bit dividend and divisor and produces an N-bit quotient and remainder. It performs one shift/subtract iteration every two clock cycles, controlled by an internal IDLE/SHIFTING/SUBTRACTING/STOPPED sequencer. It sits beside the multiplier in the arithmetic unit and uses the same start/ready handshake style.

Parameters:
N, 4, operand width in bits (dividend, divisor, quotient, remainder); legal range N >= 2.

Ports:
clock  input  1  single system clock; all state updates on its rising edge
reset_n  input  1  synchronous active-low reset, sampled on rising edge of clock
start  input  1  request a division; sampled only in IDLE or STOPPED
dividend  input  N  unsigned dividend, captured on the accepted start edge
divisor  input  N  unsigned divisor, captured on the accepted start edge
quotient  output  N  result quotient; registered
remainder  output  N  result remainder; registered
ready  output  1  high while in STOPPED (result valid)
busy  output  1  high while in SHIFTING or SUBTRACTING
div_by_zero  output  1  high in STOPPED when the captured divisor was 0

Behaviour:
- Reset: reset_n low at a rising edge forces the following, regardless of current state, including mid-operation:
  - state = IDLE, counter = 0
  - quotient = 0, remainder = 0, ready = 0, busy = 0, div_by_zero = 0
  - internal A/Q/M registers = 0
- Datapath:
  - A: N+1-bit partial remainder.
  - Q: N-bit dividend/quotient shift register.
  - M: N-bit divisor.
  - Iteration counter: $clog2(N+1) bits.
- State machine:
  - IDLE, start=1, divisor!=0: A<=0, Q<=dividend, M<=divisor, count<=N, div_by_zero<=0; go to SHIFTING.
  - IDLE, start=1, divisor==0: quotient<={N{1}}, remainder<=dividend, div_by_zero<=1; go to STOPPED (result one cycle after start).
  - IDLE, start=0: stay.
  - SHIFTING: {A,Q} <= {A,Q} << 1 (Q[0] gets 0); count <= count-1; go to SUBTRACTING.
  - SUBTRACTING: if A >= {1'b0,M} then A <= A-M and Q[0] <= 1; else A unchanged and Q[0] <= 0.
    - If count == 0: quotient <= next Q, remainder <= next A[N-1:0]; go to STOPPED.
    - Else: go to SHIFTING.
  - STOPPED, start=1: identical to IDLE start handling (new capture, back-to-back operation allowed).
  - STOPPED, start=0: stay; outputs hold.
- Latency:
  - Start accepted at edge k: ready first high after edge k+2N; busy high from edge k+1 to edge k+2N.
  - Division by zero: ready high after edge k+1.
- start while busy: ignored; operands are not re-captured.
- quotient/remainder change only on the edge entering STOPPED (including div-by-zero) or on reset. They hold the previous result during a new operation.
- ready and busy are never both high; ready is low in IDLE.
- Invariant at completion: dividend == quotient*divisor + remainder, and remainder < divisor (divisor != 0).
- Arithmetic is unsigned only; A never exceeds N bits after a restore step.

Test Plan:
- N=4, reset then start with dividend=13, divisor=3 -> busy for 8 cycles; ready after 8 edges; quotient=4, remainder=1, div_by_zero=0.
- N=4, dividend=3, divisor=5 -> quotient=0, remainder=3; then dividend=15, divisor=1 -> quotient=15, remainder=0. The second start is issued the cycle ready rises, with no IDLE gap.
- N=4, dividend=7, divisor=0 -> ready one cycle after start; quotient=4'hF, remainder=7, div_by_zero=1, busy never high.
- N=4, start 13/3, then start pulsed with 9/2 at cycle 3 -> the second start is ignored; result 4 r 1 at cycle 8.
- N=4, start 13/3, then reset_n low at cycle 4 -> all outputs 0, state IDLE next edge; a subsequent 10/4 gives 2 r 2.
- N=8, dividend=200, divisor=7 -> quotient=28, remainder=4 after 16 cycles; random sweep checks the invariant.
